// File: rtl/word_offset_seq.sv
// rtl/word_offset_seq.sv - walks a run of field words, emitting index and bit offset per beat

module word_offset_seq #(
    parameter int WORD_W = 18,
    parameter int NWORDS = 14,
    parameter int IDX_W  = 4,
    parameter int OUT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [IDX_W-1:0] len,
    input  logic             abort,
    input  logic             ready,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    output logic [OUT_W-1:0] offset,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int PW = IDX_W + OUT_W;
    localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(NWORDS);
    localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);
    localparam logic [OUT_W-1:0] STRIDE  = OUT_W'(WORD_W);

    generate
        if ((NWORDS - 1) * WORD_W >= (1 << OUT_W) || NWORDS >= (1 << IDX_W)) begin : g_bad_params
            $error("word_offset_seq: OUT_W or IDX_W too narrow for NWORDS/WORD_W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic             dir_q, dir_n;
    logic [IDX_W-1:0] len_q, len_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [OUT_W-1:0] off_q, off_n;
    logic [IDX_W-1:0] len_clamp;
    logic [PW-1:0]    top_off;
    logic             at_last;

    assign len_clamp = (len > MAX_LEN) ? MAX_LEN : len;
    // Only the descending start needs a multiply; stepping is add/subtract of WORD_W.
    assign top_off   = PW'(len_clamp - ONE) * PW'(WORD_W);
    assign at_last   = dir_q ? (idx_q == '0) : (idx_q == len_q - ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dir_q <= 1'b0;
            len_q <= '0;
            idx_q <= '0;
            off_q <= '0;
        end else begin
            state <= state_n;
            dir_q <= dir_n;
            len_q <= len_n;
            idx_q <= idx_n;
            off_q <= off_n;
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = dir_q;
        len_n   = len_q;
        idx_n   = idx_q;
        off_n   = off_q;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        dir_n   = dir;
                        len_n   = len_clamp;
                        idx_n   = dir ? len_clamp - ONE : '0;
                        off_n   = dir ? top_off[OUT_W-1:0] : '0;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    off_n   = '0;
                end else if (ready && at_last) begin
                    state_n = DONE;
                    idx_n   = '0;
                    off_n   = '0;
                end else if (ready) begin
                    idx_n = dir_q ? idx_q - ONE : idx_q + ONE;
                    off_n = dir_q ? off_q - STRIDE : off_q + STRIDE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign valid  = (state == RUN);
    assign idx    = idx_q;
    assign offset = off_q;
    assign last   = valid && at_last;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

endmodule

// File: tb/tb_word_offset_seq.sv
// tb/tb_word_offset_seq.sv - randomized self-checking bench for word_offset_seq

module tb_word_offset_seq;

    logic       clk = 1'b0;
    logic       rst, start, dir, abort, ready;
    logic [3:0] len;
    logic       valid, last, busy, done;
    logic [3:0] idx;
    logic [7:0] offset;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    word_offset_seq dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .len(len), .abort(abort),
        .ready(ready), .valid(valid), .idx(idx), .offset(offset), .last(last),
        .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat k sequence from run rules; offset = k*18. mode 0: ready=1, 1: pattern, 2: random.
    task automatic run_check(input logic d, input logic [3:0] n, input int mode, input logic [31:0] pat);
        int   l, p, cyc;
        int   exp_k[$];
        logic r;
        l = (n > 14) ? 14 : int'(n);
        exp_k.delete();
        for (int k = 0; k < l; k++) exp_k.push_back(d ? l - 1 - k : k);
        dir = d; len = n; start = 1'b1;
        tick();
        start = 1'b0;
        if (l == 0) begin
            total++;
            if (valid !== 1'b0 || done !== 1'b1) begin
                bad++;
                $display("FAIL zero_len: valid=%b done=%b required valid=0 done=1", valid, done);
            end
        end else begin
            p = 0; cyc = 0;
            while (p < l && cyc < 300) begin
                total++;
                if (valid !== 1'b1 || idx !== 4'(exp_k[p]) || offset !== 8'(exp_k[p] * 18)
                    || last !== (p == l - 1) || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL beat%0d dir=%b len=%0d: valid=%b idx=%0d off=%0d last=%b required idx=%0d off=%0d last=%b",
                             p, d, n, valid, idx, offset, last, exp_k[p], exp_k[p] * 18, p == l - 1);
                end
                r = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 32] : 1'($urandom_range(0, 1));
                ready = r;
                tick();
                ready = 1'b0;
                if (r) p++;
                cyc++;
            end
            total++;
            if (p < l) begin
                bad++;
                $display("FAIL run_timeout: beats=%0d required %0d", p, l);
            end
            total++;
            if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL done_pulse: valid=%b done=%b busy=%b required 0 1 1", valid, done, busy);
            end
        end
        tick();
        total++;
        if (valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL back_idle: valid=%b done=%b busy=%b required 0 0 0", valid, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dir = 1'b0; len = '0; abort = 1'b0; ready = 1'b0;
        tick(); tick();
        total++;
        if ({valid, idx, offset, last, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset: valid=%b idx=%0d off=%0d last=%b busy=%b done=%b required all 0",
                     valid, idx, offset, last, busy, done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_runs();
        run_check(1'b0, 4'd13, 0, 32'h0);
        run_check(1'b1, 4'd13, 0, 32'h0);
        run_check(1'b0, 4'd4, 1, 32'b1011001);
        run_check(1'b0, 4'd0, 0, 32'h0);
        run_check(1'b0, 4'd15, 0, 32'h0);
        run_check(1'b1, 4'd15, 2, 32'h0);
        run_check(1'b1, 4'd1, 2, 32'h0);
    endtask

    task automatic test_abort();
        dir = 1'b0; len = 4'd10; start = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            // Competing start during the run must not disturb it.
            start = (k == 1); dir = (k == 1); len = 4'd2;
            tick();
        end
        start = 1'b0;
        ready = 1'b0;
        total++;
        if (valid !== 1'b1 || offset !== 8'd54 || idx !== 4'd3) begin
            bad++;
            $display("FAIL pre_abort: valid=%b idx=%0d off=%0d required 1 3 54", valid, idx, offset);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort: valid=%b busy=%b done=%b required 0 0 0", valid, busy, done);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL abort_nodone: done=%b required 0", done);
        end
        run_check(1'b0, 4'd3, 0, 32'h0);
        // Abort on the final beat wins over the transfer.
        dir = 1'b0; len = 4'd2; start = 1'b1;
        tick();
        start = 1'b0; ready = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0; ready = 1'b0;
        total++;
        if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_last: valid=%b busy=%b done=%b required 0 0 0", valid, busy, done);
        end
    endtask

    task automatic test_start_in_done();
        dir = 1'b0; len = 4'd1; start = 1'b1;
        tick();
        start = 1'b0; ready = 1'b1;
        tick();
        ready = 1'b0; start = 1'b1; len = 4'd5;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            bad++;
            $display("FAIL start_in_done: busy=%b valid=%b required 0 0", busy, valid);
        end
    endtask

    task automatic test_reset_midrun();
        dir = 1'b1; len = 4'd6; start = 1'b1;
        tick();
        start = 1'b0; ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({valid, idx, offset, last, busy, done} !== '0) begin
            bad++;
            $display("FAIL reset_midrun: valid=%b idx=%0d off=%0d last=%b busy=%b done=%b required all 0",
                     valid, idx, offset, last, busy, done);
        end
    endtask

    task automatic test_soak();
        for (int i = 0; i < 25; i++)
            run_check(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2, 32'h0);
    endtask

    initial begin
        test_reset();
        test_runs();
        test_abort();
        test_start_in_done();
        test_reset_midrun();
        test_soak();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
